// File: rtl/regfile_write_arbiter_pkg.sv
// Shared CPU constants and the write-port grant encoding.
package regfile_write_arbiter_pkg;

  localparam int unsigned CPU_DATA_W   = 32;
  localparam int unsigned CPU_ADDR_W   = 5;
  localparam int unsigned CPU_LINK_REG = 31;

  // Which side received the write port most recently.
  typedef enum logic {
    GRANT_MEM = 1'b0,
    GRANT_ALU = 1'b1
  } grant_e;

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Writeback bus: ALU request, load return, register-file write port and scoreboard.
interface regfile_write_arbiter_if
  import regfile_write_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W = CPU_DATA_W,
  parameter int unsigned ADDR_W = CPU_ADDR_W
) ();

  localparam int unsigned NREG = 1 << ADDR_W;

  logic              ALU_VALID;
  logic              ALU_READY;
  logic [ADDR_W-1:0] ALU_ADDR;
  logic              ALU_LINK;
  logic [DATA_W-1:0] ALU_DATA;
  logic              MEM_VALID;
  logic [ADDR_W-1:0] MEM_ADDR;
  logic [DATA_W-1:0] MEM_DATA;
  logic              MEM_FULL;
  logic              WE;
  logic [ADDR_W-1:0] WADDR;
  logic [DATA_W-1:0] WDATA;
  logic [NREG-1:0]   PENDING;

  // Producers (ALU, load unit) and consumers (register file, decode).
  modport master (
    output ALU_VALID, ALU_ADDR, ALU_LINK, ALU_DATA,
    output MEM_VALID, MEM_ADDR, MEM_DATA,
    input  ALU_READY, MEM_FULL, WE, WADDR, WDATA, PENDING
  );

  // The arbiter itself.
  modport slave (
    input  ALU_VALID, ALU_ADDR, ALU_LINK, ALU_DATA,
    input  MEM_VALID, MEM_ADDR, MEM_DATA,
    output ALU_READY, MEM_FULL, WE, WADDR, WDATA, PENDING
  );

endinterface

// File: rtl/regfile_write_arbiter_wb_load_fifo.sv
// Two-entry load-return buffer with same-cycle push/pop at any occupancy.
module wb_load_fifo
  import regfile_write_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W = CPU_DATA_W,
  parameter int unsigned ADDR_W = CPU_ADDR_W
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   push_i,
  input  logic [ADDR_W-1:0]      push_addr_i,
  input  logic [DATA_W-1:0]      push_data_i,
  input  logic                   pop_i,
  output logic [ADDR_W-1:0]      head_addr_o,
  output logic [DATA_W-1:0]      head_data_o,
  output logic [1:0]             count_o,
  output logic [1:0]             ent_valid_o,
  output logic [1:0][ADDR_W-1:0] ent_addr_o
);

  logic [ADDR_W-1:0] addr_q [2];
  logic [DATA_W-1:0] data_q [2];
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic [1:0]        count_q, count_d;

  // Pointer and occupancy next state; push at full is always paired with a pop
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_i) wr_ptr_d = ~wr_ptr_q;
    if (pop_i)  rd_ptr_d = ~rd_ptr_q;
    count_d = count_q + 2'(push_i) - 2'(pop_i);
  end

  // Control state with synchronous reset; buffered entries are dropped
  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents only matter while counted as valid
  always_ff @(posedge CLK) begin
    if (push_i) begin
      addr_q[wr_ptr_q] <= push_addr_i;
      data_q[wr_ptr_q] <= push_data_i;
    end
  end

  assign head_addr_o = addr_q[rd_ptr_q];
  assign head_data_o = data_q[rd_ptr_q];
  assign count_o     = count_q;

  // An entry is live when the buffer is full, or when it is the lone head entry
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      ent_valid_o[i] = (count_q == 2'd2) || ((count_q == 2'd1) && (rd_ptr_q == 1'(i)));
      ent_addr_o[i]  = addr_q[i];
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Register-file write-port owner: ALU/load arbitration, write stage, pending scoreboard.
module regfile_write_arbiter
  import regfile_write_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W   = CPU_DATA_W,
  parameter int unsigned ADDR_W   = CPU_ADDR_W,
  parameter int unsigned LINK_REG = CPU_LINK_REG
) (
  input logic                    CLK,
  input logic                    RESET,
  regfile_write_arbiter_if.slave bus
);

  localparam int unsigned NREG = 1 << ADDR_W;

  logic                   push;
  logic [ADDR_W-1:0]      head_addr;
  logic [DATA_W-1:0]      head_data;
  logic [1:0]             count;
  logic [1:0]             ent_valid;
  logic [1:0][ADDR_W-1:0] ent_addr;
  logic [ADDR_W-1:0]      alu_addr_eff;
  logic                   gnt_mem_c, gnt_alu_c;
  grant_e                 last_grant_q, last_grant_d;
  logic                   we_q, we_d;
  logic [ADDR_W-1:0]      waddr_q, waddr_d;
  logic [DATA_W-1:0]      wdata_q, wdata_d;
  logic [NREG-1:0]        pending;

  assign alu_addr_eff = bus.ALU_LINK ? ADDR_W'(LINK_REG) : bus.ALU_ADDR;
  assign push         = bus.MEM_VALID && (bus.MEM_ADDR != '0);

  wb_load_fifo #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .CLK         (CLK),
    .RESET       (RESET),
    .push_i      (push),
    .push_addr_i (bus.MEM_ADDR),
    .push_data_i (bus.MEM_DATA),
    .pop_i       (gnt_mem_c),
    .head_addr_o (head_addr),
    .head_data_o (head_data),
    .count_o     (count),
    .ent_valid_o (ent_valid),
    .ent_addr_o  (ent_addr)
  );

  // Grant: a full buffer always drains (no overflow); ties alternate on last grant
  always_comb begin
    gnt_mem_c = 1'b0;
    gnt_alu_c = 1'b0;
    if (count == 2'd2) begin
      gnt_mem_c = 1'b1;
    end else if ((count != 2'd0) && bus.ALU_VALID) begin
      if (last_grant_q == GRANT_MEM) gnt_alu_c = 1'b1;
      else                           gnt_mem_c = 1'b1;
    end else if (count != 2'd0) begin
      gnt_mem_c = 1'b1;
    end else if (bus.ALU_VALID) begin
      gnt_alu_c = 1'b1;
    end
  end

  // Write-stage next state; an ALU write to r0 is accepted but not performed
  always_comb begin
    we_d         = 1'b0;
    waddr_d      = waddr_q;
    wdata_d      = wdata_q;
    last_grant_d = last_grant_q;
    if (gnt_mem_c) begin
      we_d         = 1'b1;
      waddr_d      = head_addr;
      wdata_d      = head_data;
      last_grant_d = GRANT_MEM;
    end else if (gnt_alu_c) begin
      last_grant_d = GRANT_ALU;
      if (alu_addr_eff != '0) begin
        we_d    = 1'b1;
        waddr_d = alu_addr_eff;
        wdata_d = bus.ALU_DATA;
      end
    end
  end

  // Write stage and round-robin state
  always_ff @(posedge CLK) begin
    if (RESET) begin
      we_q         <= 1'b0;
      waddr_q      <= '0;
      wdata_q      <= '0;
      last_grant_q <= GRANT_MEM;
    end else begin
      we_q         <= we_d;
      waddr_q      <= waddr_d;
      wdata_q      <= wdata_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Pending-write scoreboard over buffered loads and the active write stage
  always_comb begin
    pending = '0;
    for (int i = 0; i < 2; i++) begin
      if (ent_valid[i]) pending[ent_addr[i]] = 1'b1;
    end
    if (we_q) pending[waddr_q] = 1'b1;
    pending[0] = 1'b0;
  end

  assign bus.ALU_READY = gnt_alu_c;
  assign bus.MEM_FULL  = (count == 2'd2);
  assign bus.WE        = we_q;
  assign bus.WADDR     = waddr_q;
  assign bus.WDATA     = wdata_q;
  assign bus.PENDING   = pending;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench for regfile_write_arbiter against a queue-based reference model.
module tb_regfile_write_arbiter;

  localparam int unsigned AW = 5;
  localparam int unsigned DW = 32;
  localparam int unsigned VW = 1 + 1 + 1 + AW + DW + 32;

  logic CLK = 1'b0;
  logic RESET = 1'b1;
  always #5 CLK = ~CLK;

  regfile_write_arbiter_if bus ();

  regfile_write_arbiter dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus.slave)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: loads in a queue, write stage as plain variables
  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;

  ent_t          mq[$];
  bit            m_last_alu;
  logic          m_we;
  logic [AW-1:0] m_waddr;
  logic [DW-1:0] m_wdata;

  task automatic drive(input logic av, input logic [AW-1:0] aa, input logic al,
                       input logic [DW-1:0] ad, input logic mv,
                       input logic [AW-1:0] ma, input logic [DW-1:0] md);
    bus.ALU_VALID = av;
    bus.ALU_ADDR  = aa;
    bus.ALU_LINK  = al;
    bus.ALU_DATA  = ad;
    bus.MEM_VALID = mv;
    bus.MEM_ADDR  = ma;
    bus.MEM_DATA  = md;
    #1;
  endtask

  // 0 = nobody, 1 = load buffer, 2 = ALU
  function automatic int model_grant();
    int n = mq.size();
    if (n >= 2) return 1;
    if (n > 0 && bus.ALU_VALID) return m_last_alu ? 1 : 2;
    if (n > 0) return 1;
    if (bus.ALU_VALID) return 2;
    return 0;
  endfunction

  function automatic logic [VW-1:0] model_expect();
    logic [31:0] p = '0;
    foreach (mq[i]) p[mq[i].a] = 1'b1;
    if (m_we) p[m_waddr] = 1'b1;
    return {model_grant() == 2, mq.size() == 2, m_we, m_waddr, m_wdata, p};
  endfunction

  function automatic logic [VW-1:0] dut_observe();
    return {bus.ALU_READY, bus.MEM_FULL, bus.WE, bus.WADDR, bus.WDATA, bus.PENDING};
  endfunction

  task automatic advance();
    int            g;
    ent_t          e;
    ent_t          h;
    logic [AW-1:0] eff;
    bit            push;
    g    = model_grant();
    eff  = bus.ALU_LINK ? 5'd31 : bus.ALU_ADDR;
    push = bus.MEM_VALID && (bus.MEM_ADDR != '0);
    e    = {bus.MEM_ADDR, bus.MEM_DATA};
    @(posedge CLK);
    #1;
    m_we = 1'b0;
    if (g == 1) begin
      h = mq.pop_front();
      m_we = 1'b1;
      m_waddr = h.a;
      m_wdata = h.d;
      m_last_alu = 1'b0;
    end else if (g == 2) begin
      m_last_alu = 1'b1;
      if (eff != '0) begin
        m_we = 1'b1;
        m_waddr = eff;
        m_wdata = bus.ALU_DATA;
      end
    end
    if (push) mq.push_back(e);
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    mq.delete();
    m_last_alu = 1'b0;
    m_we = 1'b0;
    m_waddr = '0;
    m_wdata = '0;
  endtask

  task automatic test_reset();
    drive(0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge CLK);
    #1;
    RESET = 1'b0;
    mq.delete();
    m_last_alu = 1'b0;
    m_we = 1'b0;
    m_waddr = '0;
    m_wdata = '0;
    checks++;
    if (dut_observe() !== '0) begin
      errors++;
      $display("FAIL reset_state: got %h want 0", dut_observe());
    end
    drive(1, 5'd9, 0, 32'h1, 0, 0, 0);
    checks++;
    if (bus.ALU_READY !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready_comb: got %b want 1", bus.ALU_READY);
    end
    drive(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_alu_basic();
    do_reset();
    drive(1, 5'd5, 0, 32'hDEADBEEF, 0, 0, 0);
    checks++;
    if (bus.ALU_READY !== 1'b1) begin
      errors++;
      $display("FAIL alu_ready: got %b want 1", bus.ALU_READY);
    end
    advance();
    drive(1, 5'd7, 1, 32'h00400010, 0, 0, 0);
    checks++;
    if ({bus.WE, bus.WADDR, bus.WDATA, bus.PENDING} !== {1'b1, 5'd5, 32'hDEADBEEF, 32'h20}) begin
      errors++;
      $display("FAIL alu_write: got %b/%0d/%h/%h want 1/5/deadbeef/00000020",
               bus.WE, bus.WADDR, bus.WDATA, bus.PENDING);
    end
    advance();
    drive(1, 5'd0, 0, 32'h1234, 0, 0, 0);
    checks++;
    if ({bus.WE, bus.WADDR, bus.WDATA, bus.PENDING[31]} !== {1'b1, 5'd31, 32'h00400010, 1'b1}) begin
      errors++;
      $display("FAIL link_write: got %b/%0d/%h/%b want 1/31/00400010/1",
               bus.WE, bus.WADDR, bus.WDATA, bus.PENDING[31]);
    end
    checks++;
    if (bus.ALU_READY !== 1'b1) begin
      errors++;
      $display("FAIL r0_ready: got %b want 1", bus.ALU_READY);
    end
    advance();
    drive(0, 0, 0, 0, 0, 0, 0);
    checks++;
    if ({bus.WE, bus.PENDING} !== {1'b0, 32'h0}) begin
      errors++;
      $display("FAIL r0_no_write: got we=%b pend=%h want 0/0", bus.WE, bus.PENDING);
    end
    advance();
  endtask

  task automatic test_interleave();
    logic [AW-1:0] seq[$];
    logic [14:0]   got;
    do_reset();
    for (int c = 0; c < 8; c++) begin
      drive(1, 5'd4, 0, 32'hA0 + 32'(c), 1, 5'd3, 32'h11);
      checks++;
      if (dut_observe() !== model_expect()) begin
        errors++;
        $display("FAIL interleave c%0d: got %h want %h", c, dut_observe(), model_expect());
      end
      if (bus.WE) seq.push_back(bus.WADDR);
      advance();
    end
    got = (seq.size() >= 3) ? {seq[0], seq[1], seq[2]} : '0;
    checks++;
    if (got !== {5'd4, 5'd3, 5'd4}) begin
      errors++;
      $display("FAIL interleave_order: got %h want %h", got, {5'd4, 5'd3, 5'd4});
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    repeat (3) advance();
  endtask

  task automatic test_full();
    logic [AW-1:0] loads[$];
    logic [14:0]   got;
    bit            seen_full = 0;
    do_reset();
    for (int c = 0; c < 9; c++) begin
      drive(1, 5'd9, 0, 32'h900 + 32'(c), (c < 3), 5'(c + 1), 32'h100 + 32'(c));
      checks++;
      if (dut_observe() !== model_expect()) begin
        errors++;
        $display("FAIL full c%0d: got %h want %h", c, dut_observe(), model_expect());
      end
      if (bus.MEM_FULL) begin
        seen_full = 1;
        checks++;
        if (bus.ALU_READY !== 1'b0) begin
          errors++;
          $display("FAIL full_blocks_alu c%0d: got %b want 0", c, bus.ALU_READY);
        end
      end
      if (bus.WE && bus.WADDR != 5'd9) loads.push_back(bus.WADDR);
      advance();
    end
    checks++;
    if (!seen_full) begin
      errors++;
      $display("FAIL full_seen: got 0 want 1");
    end
    got = (loads.size() == 3) ? {loads[0], loads[1], loads[2]} : '0;
    checks++;
    if (got !== {5'd1, 5'd2, 5'd3}) begin
      errors++;
      $display("FAIL full_load_order: got %h (n=%0d) want %h", got, loads.size(), {5'd1, 5'd2, 5'd3});
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    repeat (3) advance();
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int c = 0; c < 3; c++) begin
      drive(1, 5'd9, 0, 32'h5, 1, 5'(c + 1), 32'h200 + 32'(c));
      advance();
    end
    checks++;
    if ({bus.MEM_FULL, bus.WE} !== 2'b11) begin
      errors++;
      $display("FAIL pre_reset: got full=%b we=%b want 1/1", bus.MEM_FULL, bus.WE);
    end
    do_reset();
    checks++;
    if ({bus.ALU_READY, bus.MEM_FULL, bus.WE, bus.PENDING} !== '0) begin
      errors++;
      $display("FAIL mid_reset: got rdy=%b full=%b we=%b pend=%h want 0", bus.ALU_READY,
               bus.MEM_FULL, bus.WE, bus.PENDING);
    end
    for (int c = 0; c < 3; c++) begin
      advance();
      checks++;
      if ({bus.WE, bus.PENDING} !== '0) begin
        errors++;
        $display("FAIL mid_reset_drain c%0d: got we=%b pend=%h want 0", c, bus.WE, bus.PENDING);
      end
    end
  endtask

  task automatic test_mem_addr0();
    do_reset();
    drive(0, 0, 0, 0, 1, 5'd6, 32'h66);
    advance();
    drive(0, 0, 0, 0, 1, 5'd0, 32'h77);
    checks++;
    if ({bus.PENDING, bus.MEM_FULL} !== {32'h40, 1'b0}) begin
      errors++;
      $display("FAIL addr0_hold: got pend=%h full=%b want 00000040/0", bus.PENDING, bus.MEM_FULL);
    end
    advance();
    drive(0, 0, 0, 0, 0, 0, 0);
    checks++;
    if ({bus.WE, bus.WADDR, bus.WDATA, bus.PENDING} !== {1'b1, 5'd6, 32'h66, 32'h40}) begin
      errors++;
      $display("FAIL addr0_r6_write: got %b/%0d/%h/%h want 1/6/66/40",
               bus.WE, bus.WADDR, bus.WDATA, bus.PENDING);
    end
    advance();
    checks++;
    if ({bus.WE, bus.PENDING} !== '0) begin
      errors++;
      $display("FAIL addr0_dropped: got we=%b pend=%h want 0/0", bus.WE, bus.PENDING);
    end
    drive(0, 0, 0, 0, 1, 5'd0, 32'h88);
    advance();
    drive(0, 0, 0, 0, 0, 0, 0);
    advance();
    checks++;
    if ({bus.WE, bus.MEM_FULL, bus.PENDING} !== '0) begin
      errors++;
      $display("FAIL addr0_alone: got we=%b full=%b pend=%h want 0", bus.WE, bus.MEM_FULL, bus.PENDING);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 96) == 0) do_reset();
      drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), ($urandom_range(0, 3) == 0),
            $urandom, ($urandom_range(0, 2) != 0), 5'($urandom_range(0, 31)), $urandom);
      checks++;
      if (dut_observe() !== model_expect()) begin
        errors++;
        $display("FAIL random c%0d: got %h want %h", c, dut_observe(), model_expect());
      end
      advance();
    end
  endtask

  initial begin
    test_reset();
    test_alu_basic();
    test_interleave();
    test_full();
    test_reset_mid();
    test_mem_addr0();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
